resultado_display: RTL and testbench

- Receiving end of the ALU's sign-magnitude result path: accepts sign flag plus 5-bit magnitude, converts the magnitude to BCD with a multi-cycle shift-add-3 sequencer, and drives a 3-digit multiplexed 7-segment display (sign, tens, units).
- Sits between the processor result register and the board display pins.

---
 rtl/display_pkg.sv | 29 ++
 rtl/seg7_decoder.sv | 28 ++
 rtl/resultado_display.sv | 160 ++++++++++++++++
 tb/tb_resultado_display.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the resultado_display slice.
//   - FSM state encoding for the BCD conversion sequencer
//   - digit-slot indices used by the multiplexed scan
//   - active-low segment patterns for blank and minus
//   - conversion length and the shift-add-3 nibble adjust helper
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_UPDATE = 2'd2
    } state_e;

    localparam logic [1:0] DIG_UNITS = 2'd0;
    localparam logic [1:0] DIG_TENS  = 2'd1;
    localparam logic [1:0] DIG_SIGN  = 2'd2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam int unsigned CONV_BITS = 5;
    localparam logic [2:0]  LAST_BIT  = 3'(CONV_BITS - 1);

    // Double-dabble correction applied to a BCD nibble before each shift.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? (n + 4'd3) : n;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational 4-bit value to 7-segment lookup.
//   val_i [3:0]  digit value; 0..9 decoded, anything else blank
//   seg_o [6:0]  segments {g,f,e,d,c,b,a}, active-low
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] val_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (val_i)
            4'd0:    seg_o = 7'b1000000;
            4'd1:    seg_o = 7'b1111001;
            4'd2:    seg_o = 7'b0100100;
            4'd3:    seg_o = 7'b0110000;
            4'd4:    seg_o = 7'b0011001;
            4'd5:    seg_o = 7'b0010010;
            4'd6:    seg_o = 7'b0000010;
            4'd7:    seg_o = 7'b1111000;
            4'd8:    seg_o = 7'b0000000;
            4'd9:    seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/resultado_display.sv
// resultado_display: receives the ALU sign-magnitude result, converts the
// 5-bit magnitude to BCD with a shift-add-3 sequencer (one bit per cycle),
// and drives a 3-digit multiplexed 7-segment display (sign, tens, units).
//   clk          system clock, rising edge
//   rst_n        synchronous reset, active-low
//   load         one-cycle strobe sampling s_in/mag_in (ignored while busy)
//   s_in         result sign, 1 = negative
//   mag_in [4:0] result magnitude 0..31
//   busy         conversion in progress
//   done         one-cycle pulse when the display registers take a new value
//   seg [6:0]    segments {g,f,e,d,c,b,a}, active-low
//   an  [2:0]    digit enables {sign,tens,units}, active-low
// Build option: define LEADING_ZERO_BLANK_EN to blank the tens digit when it
// is zero; otherwise a leading '0' is shown.
module resultado_display
    import display_pkg::*;
#(
    parameter logic [15:0] REFRESH_DIV = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       s_in,
    input  logic [4:0] mag_in,
    output logic       busy,
    output logic       done,
    output logic [6:0] seg,
    output logic [2:0] an
);

    state_e     state_q;
    logic [4:0] mag_q;
    logic       sign_q;
    logic [7:0] bcd_q;
    logic [7:0] bcd_adj;
    logic [2:0] bitcnt_q;
    logic       busy_q;
    logic       done_q;

    logic       disp_sign_q;
    logic [3:0] disp_tens_q;
    logic [3:0] disp_units_q;

    logic [15:0] refresh_q;
    logic [1:0]  dig_q;
    logic [1:0]  dig_d;
    logic [6:0]  seg_q;
    logic [6:0]  seg_d;
    logic [2:0]  an_q;
    logic [2:0]  an_d;
    logic [3:0]  nibble;
    logic [6:0]  dec_seg;

    assign bcd_adj = {bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};

    // Conversion sequencer. The negative-zero check is folded into the
    // latched sign so the display path never sees a "-0".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mag_q        <= '0;
            sign_q       <= 1'b0;
            bcd_q        <= '0;
            bitcnt_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            disp_sign_q  <= 1'b0;
            disp_tens_q  <= '0;
            disp_units_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load) begin
                        mag_q    <= mag_in;
                        sign_q   <= s_in & (|mag_in);
                        bcd_q    <= '0;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ST_CONV;
                    end
                end
                ST_CONV: begin
                    {bcd_q, mag_q} <= {bcd_adj, mag_q} << 1;
                    if (bitcnt_q == LAST_BIT) begin
                        state_q <= ST_UPDATE;
                    end else begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                    end
                end
                ST_UPDATE: begin
                    disp_sign_q  <= sign_q;
                    disp_tens_q  <= bcd_q[7:4];
                    disp_units_q <= bcd_q[3:0];
                    done_q       <= 1'b1;
                    busy_q       <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign nibble = (dig_q == DIG_TENS) ? disp_tens_q : disp_units_q;

    seg7_decoder u_dec (
        .val_i (nibble),
        .seg_o (dec_seg)
    );

    always_comb begin
        seg_d = dec_seg;
        an_d  = 3'b110;
        dig_d = DIG_TENS;
        case (dig_q)
            DIG_TENS: begin
                an_d  = 3'b101;
                dig_d = DIG_SIGN;
`ifdef LEADING_ZERO_BLANK_EN
                if (disp_tens_q == 4'd0) seg_d = SEG_BLANK;
`endif
            end
            DIG_SIGN: begin
                an_d  = 3'b011;
                dig_d = DIG_UNITS;
                seg_d = disp_sign_q ? SEG_MINUS : SEG_BLANK;
            end
            default: begin
                an_d  = 3'b110;
                dig_d = DIG_TENS;
            end
        endcase
    end

    // Free-running scan; an and seg are registered together so a digit
    // never shows its neighbour's pattern.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_q <= '0;
            dig_q     <= DIG_UNITS;
            seg_q     <= SEG_BLANK;
            an_q      <= 3'b111;
        end else begin
            if (refresh_q == REFRESH_DIV - 16'd1) begin
                refresh_q <= '0;
                dig_q     <= dig_d;
            end else begin
                refresh_q <= refresh_q + 16'd1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_resultado_display.sv
module tb_resultado_display;

    typedef struct packed {
        logic       sign;
        logic [3:0] tens;
        logic [3:0] units;
    } disp_t;

    logic       clk;
    logic       rst_n;
    logic       load;
    logic       s_in;
    logic [4:0] mag_in;
    logic       busy;
    logic       done;
    logic [6:0] seg;
    logic [2:0] an;

    int    checks;
    int    errors;
    disp_t sb[$];

    logic [6:0] segtab [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000};

    resultado_display #(.REFRESH_DIV(16'd4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .s_in   (s_in),
        .mag_in (mag_in),
        .busy   (busy),
        .done   (done),
        .seg    (seg),
        .an     (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic disp_t model(input logic s, input logic [4:0] m);
        disp_t d;
        d.sign  = s && (m != 5'd0);
        d.tens  = 4'(int'(m) / 10);
        d.units = 4'(int'(m) % 10);
        return d;
    endfunction

    function automatic logic [6:0] exp_tens_seg(input logic [3:0] t);
`ifdef LEADING_ZERO_BLANK_EN
        if (t == 4'd0) return 7'h7F;
`endif
        return segtab[t];
    endfunction

    // Wait (bounded) for a given digit slot and return its segments.
    task automatic observe_slot(input logic [2:0] want, output logic [6:0] s);
        int k;
        k = 0;
        while (an !== want && k < 20) begin
            tick();
            k++;
        end
        chk("slot_reached", {13'd0, an}, {13'd0, want});
        s = seg;
    endtask

    task automatic check_display(input string tag, input disp_t d);
        logic [6:0] s;
        observe_slot(3'b110, s);
        chk({tag, "_units"}, {9'd0, s}, {9'd0, segtab[d.units]});
        observe_slot(3'b101, s);
        chk({tag, "_tens"}, {9'd0, s}, {9'd0, exp_tens_seg(d.tens)});
        observe_slot(3'b011, s);
        chk({tag, "_sign"}, {9'd0, s}, {9'd0, (d.sign ? 7'b0111111 : 7'h7F)});
    endtask

    task automatic do_load(input logic s, input logic [4:0] m, input logic push);
        if (push) sb.push_back(model(s, m));
        load   = 1'b1;
        s_in   = s;
        mag_in = m;
        tick();
        load   = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int k);
        logic busy_ok;
        k = 0;
        busy_ok = 1'b1;
        while (done !== 1'b1 && k < 20) begin
            tick();
            k++;
            if (done !== 1'b1 && busy !== 1'b1) busy_ok = 1'b0;
        end
        chk({tag, "_done_seen"}, {15'd0, done}, 16'd1);
        chk({tag, "_busy_held"}, {15'd0, busy_ok}, 16'd1);
        chk({tag, "_busy_clr"}, {15'd0, busy}, 16'd0);
    endtask

    task automatic run_txn(input string tag, input logic s, input logic [4:0] m);
        int    k;
        disp_t e;
        do_load(s, m, 1'b1);
        chk({tag, "_busy_set"}, {15'd0, busy}, 16'd1);
        wait_done(tag, k);
        chk({tag, "_latency"}, 16'(k), 16'd6);
        e = sb.pop_front();
        tick();
        chk({tag, "_done_pulse"}, {15'd0, done}, 16'd0);
        check_display(tag, e);
    endtask

    initial begin
        int    k;
        int    pulses;
        disp_t e;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        load   = 1'b0;
        s_in   = 1'b0;
        mag_in = '0;

        // reset held three cycles
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_seg", {9'd0, seg}, 16'h007F);
            chk("rst_an", {13'd0, an}, 16'h0007);
            chk("rst_busy", {15'd0, busy}, 16'd0);
        end
        rst_n = 1'b1;
        tick();
        chk("scan0_an", {13'd0, an}, 16'h0006);
        chk("scan0_seg", {9'd0, seg}, {9'd0, segtab[0]});
        for (int i = 0; i < 4; i++) tick();
        chk("scan1_an", {13'd0, an}, 16'h0005);
        chk("scan1_seg", {9'd0, seg}, {9'd0, exp_tens_seg(4'd0)});
        for (int i = 0; i < 4; i++) tick();
        chk("scan2_an", {13'd0, an}, 16'h0003);
        chk("scan2_seg", {9'd0, seg}, 16'h007F);
        for (int i = 0; i < 4; i++) tick();
        chk("scan3_an", {13'd0, an}, 16'h0006);

        run_txn("neg13", 1'b1, 5'd13);
        run_txn("negzero", 1'b1, 5'd0);
        run_txn("max31", 1'b0, 5'd31);
        run_txn("pos7", 1'b0, 5'd7);

        // back-to-back: load on the cycle done is high
        do_load(1'b0, 5'd5, 1'b1);
        wait_done("b2b_a", k);
        e = sb.pop_front();
        do_load(1'b1, 5'd20, 1'b1);
        chk("b2b_accept", {15'd0, busy}, 16'd1);
        wait_done("b2b_b", k);
        chk("b2b_latency", 16'(k), 16'd6);
        e = sb.pop_front();
        tick();
        check_display("b2b", e);

        // load while busy is ignored
        do_load(1'b0, 5'd9, 1'b1);
        tick();
        do_load(1'b1, 5'd22, 1'b0);
        wait_done("lwb", k);
        chk("lwb_latency", 16'(k), 16'd4);
        e = sb.pop_front();
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("lwb_single_done", 16'(pulses), 16'd0);
        check_display("lwb", e);

        // reset at edge N+3 of a conversion
        do_load(1'b0, 5'd27, 1'b0);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_an", {13'd0, an}, 16'h0007);
        chk("abort_seg", {9'd0, seg}, 16'h007F);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk("abort_no_done", 16'(pulses), 16'd0);
        chk("abort_idle", {15'd0, busy}, 16'd0);
        check_display("abort", model(1'b0, 5'd0));

        chk("sb_empty", 16'(sb.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
